rr_path_arbiter: RTL and testbench

Five-requester round-robin arbiter with per-requester one-entry buffers. It sits directly upstream of the one-hot path mux. It drives that mux's five data inputs and its one-hot select, and it holds both stable under a valid/ready handshake until the consumer accepts. Its job is to guarantee the select is strictly one-hot (or zero when idle) and that every requester is served fairly.

---
 rtl/rr_path_arbiter_if.sv | 42 ++++
 rtl/rr_path_arbiter.sv | 150 +++++++++++++++
 tb/tb_rr_path_arbiter.sv | 197 +++++++++++++++++++
 3 files changed

// File: rtl/rr_path_arbiter_if.sv
`default_nettype none
// ============================================================================
//  Module      : rr_path_arbiter_if
//  Description : Requester, mux-data and consumer handshake bundle of the
//                five-way round-robin path arbiter.
//  Revision    : 1.0 - initial release
// ============================================================================
interface rr_path_arbiter_if #(
    parameter int WIDTH = 8
);
    logic [4:0]       io_req_valid;
    logic [4:0]       io_req_ready;
    logic [WIDTH-1:0] io_req_data_1;
    logic [WIDTH-1:0] io_req_data_2;
    logic [WIDTH-1:0] io_req_data_3;
    logic [WIDTH-1:0] io_req_data_4;
    logic [WIDTH-1:0] io_req_data_5;
    logic [WIDTH-1:0] io_in1;
    logic [WIDTH-1:0] io_in2;
    logic [WIDTH-1:0] io_in3;
    logic [WIDTH-1:0] io_in4;
    logic [WIDTH-1:0] io_in5;
    logic [4:0]       io_path;
    logic             io_valid;
    logic             io_ready;

    // master: the arbiter itself; slave: requesters plus consumer
    modport master (
        input  io_req_valid, io_req_data_1, io_req_data_2, io_req_data_3,
               io_req_data_4, io_req_data_5, io_ready,
        output io_req_ready, io_in1, io_in2, io_in3, io_in4, io_in5,
               io_path, io_valid
    );

    modport slave (
        output io_req_valid, io_req_data_1, io_req_data_2, io_req_data_3,
               io_req_data_4, io_req_data_5, io_ready,
        input  io_req_ready, io_in1, io_in2, io_in3, io_in4, io_in5,
               io_path, io_valid
    );
endinterface
`default_nettype wire

// File: rtl/rr_path_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : rr_path_arbiter
//  Description : Five-requester round-robin arbiter with one-entry slots,
//                driving a one-hot path mux under a valid/ready handshake.
//  Revision    : 1.0 - initial release
// ============================================================================
module rr_path_arbiter #(
    parameter int WIDTH = 8
) (
    input  logic               clock,
    input  logic               reset,
    rr_path_arbiter_if.master  bus
);
    localparam int C_NREQ = 5;

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_GRANT = 1'b1
    } state_t;

    state_t           r_state;
    state_t           w_state_nxt;
    logic [4:0]       r_gnt;
    logic [4:0]       w_gnt_nxt;
    logic [2:0]       r_idx;
    logic [2:0]       w_idx_nxt;
    logic [2:0]       r_ptr;
    logic [2:0]       w_ptr_nxt;
    logic [4:0]       r_full;
    logic [WIDTH-1:0] r_buf [C_NREQ];
    logic [WIDTH-1:0] w_req_data [C_NREQ];

    logic             w_xfer;
    logic [4:0]       w_drain;
    logic [4:0]       w_cand;
    logic [4:0]       w_capture;
    logic [2:0]       w_base;
    logic [2:0]       w_win_idx;
    logic [4:0]       w_win;
    logic             w_found;

    assign w_req_data[0] = bus.io_req_data_1;
    assign w_req_data[1] = bus.io_req_data_2;
    assign w_req_data[2] = bus.io_req_data_3;
    assign w_req_data[3] = bus.io_req_data_4;
    assign w_req_data[4] = bus.io_req_data_5;

    assign w_xfer    = (r_state == ST_GRANT) && bus.io_ready;
    assign w_drain   = w_xfer ? r_gnt : 5'b00000;
    assign w_cand    = r_full & ~w_drain;
    assign w_capture = bus.io_req_valid & ~r_full;
    // On a transfer the just-served slot becomes the new rotation origin
    assign w_base    = (r_state == ST_GRANT) ? r_idx : r_ptr;
    assign w_win     = 5'b00001 << w_win_idx;

    // Scan farthest-to-nearest so the nearest candidate after w_base wins
    always_comb begin : p_scan
        int         s;
        logic [2:0] k;
        w_found   = 1'b0;
        w_win_idx = 3'd0;
        s         = 0;
        k         = 3'd0;
        for (int i = C_NREQ; i >= 1; i--) begin
            s = (int'(w_base) + i) % C_NREQ;
            k = 3'(s);
            if (w_cand[k]) begin
                w_found   = 1'b1;
                w_win_idx = k;
            end
        end
    end

    always_comb begin : p_fsm_nxt
        w_state_nxt = r_state;
        w_gnt_nxt   = r_gnt;
        w_idx_nxt   = r_idx;
        w_ptr_nxt   = r_ptr;
        case (r_state)
            ST_IDLE: begin
                if (w_found) begin
                    w_state_nxt = ST_GRANT;
                    w_gnt_nxt   = w_win;
                    w_idx_nxt   = w_win_idx;
                end
            end
            ST_GRANT: begin
                if (bus.io_ready) begin
                    w_ptr_nxt = r_idx;
                    if (w_found) begin
                        w_gnt_nxt = w_win;
                        w_idx_nxt = w_win_idx;
                    end else begin
                        w_state_nxt = ST_IDLE;
                        w_gnt_nxt   = 5'b00000;
                    end
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
                w_gnt_nxt   = 5'b00000;
            end
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin : p_fsm_reg
        if (!reset) begin
            r_state <= ST_IDLE;
            r_gnt   <= 5'b00000;
            r_idx   <= 3'd0;
            r_ptr   <= 3'd4;
        end else begin
            r_state <= w_state_nxt;
            r_gnt   <= w_gnt_nxt;
            r_idx   <= w_idx_nxt;
            r_ptr   <= w_ptr_nxt;
        end
    end

    // A granted slot is full, so it can never be captured into and drained at once
    always_ff @(posedge clock or negedge reset) begin : p_slots
        if (!reset) begin
            r_full <= 5'b00000;
            for (int k = 0; k < C_NREQ; k++) begin
                r_buf[k] <= '0;
            end
        end else begin
            for (int k = 0; k < C_NREQ; k++) begin
                if (w_capture[k]) begin
                    r_full[k] <= 1'b1;
                    r_buf[k]  <= w_req_data[k];
                end else if (w_drain[k]) begin
                    r_full[k] <= 1'b0;
                end
            end
        end
    end

    assign bus.io_req_ready = ~r_full;
    assign bus.io_path      = r_gnt;
    assign bus.io_valid     = (r_state == ST_GRANT);
    assign bus.io_in1       = r_buf[0];
    assign bus.io_in2       = r_buf[1];
    assign bus.io_in3       = r_buf[2];
    assign bus.io_in4       = r_buf[3];
    assign bus.io_in5       = r_buf[4];

endmodule
`default_nettype wire

// File: tb/tb_rr_path_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_rr_path_arbiter
//  Description : Randomized and directed bench for rr_path_arbiter against a
//                slot/queue-level reference model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_rr_path_arbiter;
    logic clock = 1'b0;
    logic reset = 1'b1;

    always #5 clock = ~clock;

    rr_path_arbiter_if #(.WIDTH(8)) bus();

    rr_path_arbiter #(.WIDTH(8)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    int n_checks = 0;
    int n_fail   = 0;

    bit         m_full [5];
    logic [7:0] m_buf  [5];
    int         m_ptr;
    bit         m_busy;
    int         m_g;

    task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: observed=%0h expected=%0h (t=%0t)", tag, act, exp, $time);
        end
    endtask

    task automatic drive(input logic [4:0] v, input logic [39:0] d, input logic rdy);
        bus.io_req_valid  = v;
        bus.io_req_data_1 = d[7:0];
        bus.io_req_data_2 = d[15:8];
        bus.io_req_data_3 = d[23:16];
        bus.io_req_data_4 = d[31:24];
        bus.io_req_data_5 = d[39:32];
        bus.io_ready      = rdy;
    endtask

    task automatic model_reset();
        for (int k = 0; k < 5; k++) begin
            m_full[k] = 1'b0;
            m_buf[k]  = 8'h00;
        end
        m_ptr  = 4;
        m_busy = 1'b0;
        m_g    = 0;
    endtask

    // One clock of behaviour: serve/rotate first, then accept new items
    task automatic model_update(input logic [4:0] v, input logic [39:0] d, input logic rdy);
        bit rp [5];
        int drn;
        int base;
        for (int k = 0; k < 5; k++) rp[k] = !m_full[k];
        drn = (m_busy && rdy) ? m_g : -1;
        if (!m_busy || drn >= 0) begin
            base = m_ptr;
            if (drn >= 0) begin
                m_full[drn] = 1'b0;
                m_ptr       = drn;
                base        = drn;
            end
            m_busy = 1'b0;
            for (int i = 1; i <= 5; i++) begin
                if (m_full[(base + i) % 5]) begin
                    m_busy = 1'b1;
                    m_g    = (base + i) % 5;
                    break;
                end
            end
        end
        for (int k = 0; k < 5; k++) begin
            if (v[k] && rp[k]) begin
                m_full[k] = 1'b1;
                m_buf[k]  = d[8*k +: 8];
            end
        end
    endtask

    task automatic check_outputs();
        logic [4:0]  exp_path;
        logic [4:0]  exp_rdy;
        logic [39:0] exp_in;
        logic [39:0] act_in;
        exp_path = m_busy ? 5'(1 << m_g) : 5'b00000;
        for (int k = 0; k < 5; k++) begin
            exp_rdy[k]     = !m_full[k];
            exp_in[8*k +: 8] = m_buf[k];
        end
        act_in = {bus.io_in5, bus.io_in4, bus.io_in3, bus.io_in2, bus.io_in1};
        chk("io_valid", 64'(bus.io_valid), 64'(m_busy));
        chk("io_path", 64'(bus.io_path), 64'(exp_path));
        chk("io_req_ready", 64'(bus.io_req_ready), 64'(exp_rdy));
        chk("io_in", 64'(act_in), 64'(exp_in));
    endtask

    task automatic step(input logic [4:0] v, input logic [39:0] d, input logic rdy);
        drive(v, d, rdy);
        @(posedge clock);
        model_update(v, d, rdy);
        @(negedge clock);
        check_outputs();
    endtask

    function automatic logic [39:0] rnd_data();
        return 40'({$urandom(), $urandom()});
    endfunction

    // Called just after a falling edge: async assert, check before next rise, release mid-cycle
    task automatic do_reset();
        #2 reset = 1'b0;
        #1 model_reset();
        check_outputs();
        @(negedge clock);
        check_outputs();
        #2 reset = 1'b1;
    endtask

    initial begin
        drive(5'b00000, 40'h0, 1'b0);
        #1 reset = 1'b0;
        model_reset();
        repeat (3) begin
            drive(5'($urandom), rnd_data(), 1'($urandom));
            @(negedge clock);
            check_outputs();
        end
        #2 reset = 1'b1;

        // single request on requester 2
        step(5'b00100, {16'h0, 8'hA5, 16'h0}, 1'b1);
        repeat (4) step(5'b00000, rnd_data(), 1'b1);

        // all five captured together
        do_reset();
        step(5'b11111, rnd_data(), 1'b1);
        repeat (7) step(5'b00000, rnd_data(), 1'b1);

        // backpressure on grant 00010 while slot 0 fills
        do_reset();
        step(5'b00010, rnd_data(), 1'b0);
        step(5'b00000, rnd_data(), 1'b0);
        step(5'b00001, rnd_data(), 1'b0);
        step(5'b10000, rnd_data(), 1'b0);
        step(5'b00000, rnd_data(), 1'b0);
        repeat (5) step(5'b00000, rnd_data(), 1'b1);

        // wrap fairness between requesters 4 and 0
        do_reset();
        repeat (20) step(5'b10001, rnd_data(), 1'b1);
        repeat (3) step(5'b00000, rnd_data(), 1'b1);

        // reset while path 01000 is granted
        do_reset();
        step(5'b01000, rnd_data(), 1'b0);
        begin
            int t;
            t = 0;
            while (!m_busy && t < 10) begin
                step(5'b00000, rnd_data(), 1'b0);
                t++;
            end
            if (t >= 10) chk("grant_timeout", 64'(1), 64'(0));
        end
        chk("pre_reset_path", 64'(bus.io_path), 64'(5'b01000));
        do_reset();
        step(5'b00000, rnd_data(), 1'b1);

        // random traffic with one asynchronous reset in the middle
        for (int n = 0; n < 600; n++) begin
            logic [4:0] v;
            if (n == 300) do_reset();
            v = (n % 100 < 50) ? 5'($urandom() & $urandom()) : 5'($urandom());
            step(v, rnd_data(), $urandom_range(0, 3) != 0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end
endmodule
`default_nettype wire
